// File: rtl/acorr_detector.sv
// Autocorrelation packet detector: magnitude vs. power ratio test with run length, holdoff and a saturating detection counter.
// Optional macro ACORR_DETECTOR_METRIC_OUT_EN exposes the stage-2 magnitude as o_metric/o_metric_valid.
module acorr_detector #(
    parameter int INPUT_WIDTH   = 39,
    parameter int THRESH_WIDTH  = 8,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [INPUT_WIDTH-1:0]   i_acorr_re,
    input  logic [INPUT_WIDTH-1:0]   i_acorr_im,
    input  logic [INPUT_WIDTH-1:0]   i_power,
    input  logic                     i_valid,
    input  logic [THRESH_WIDTH-1:0]  i_thresh,
    input  logic [INPUT_WIDTH-1:0]   i_pow_floor,
    input  logic [7:0]               i_min_run,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    output logic                     o_detect,
    output logic [HOLDOFF_WIDTH-1:0] o_det_count,
`ifdef ACORR_DETECTOR_METRIC_OUT_EN
    output logic [INPUT_WIDTH:0]     o_metric,
    output logic                     o_metric_valid,
`endif
    output logic [1:0]               o_state
);

    localparam int MW = INPUT_WIDTH + 1;
    localparam int PW = 48;
    localparam logic [INPUT_WIDTH-1:0]   MOST_NEG = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
    localparam logic [INPUT_WIDTH-1:0]   MAX_POS  = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
    localparam logic [INPUT_WIDTH-1:0]   IN_ONE   = {{(INPUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Absolute value where the most-negative code clamps instead of wrapping.
    function automatic logic [INPUT_WIDTH-1:0] sat_abs(input logic [INPUT_WIDTH-1:0] x);
        if (x == MOST_NEG)
            return MAX_POS;
        else if (x[INPUT_WIDTH-1])
            return (~x) + IN_ONE;
        else
            return x;
    endfunction

    // Stage 1
    logic                   r_v1;
    logic [INPUT_WIDTH-1:0] r_abs_re;
    logic [INPUT_WIDTH-1:0] r_abs_im;
    logic [INPUT_WIDTH-1:0] r_pow1;

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_v1     <= 1'b0;
            r_abs_re <= '0;
            r_abs_im <= '0;
            r_pow1   <= '0;
        end else begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_abs_re <= sat_abs(i_acorr_re);
                r_abs_im <= sat_abs(i_acorr_im);
                r_pow1   <= i_power;
            end
        end
    end

    // Stage 2: alpha-max-plus-beta-min magnitude and the cross-multiplied ratio test.
    logic [INPUT_WIDTH-1:0] w_max;
    logic [INPUT_WIDTH-1:0] w_min;
    logic [MW-1:0]          w_mag;
    logic [PW-1:0]          w_lhs;
    logic [PW-1:0]          w_rhs;

    always_comb begin
        w_max = (r_abs_re >= r_abs_im) ? r_abs_re : r_abs_im;
        w_min = (r_abs_re >= r_abs_im) ? r_abs_im : r_abs_re;
        w_mag = {1'b0, w_max} + {2'b00, w_min[INPUT_WIDTH-1:1]};
        w_lhs = PW'({w_mag, 5'b00000});
        w_rhs = PW'(r_pow1) * PW'(i_thresh);
    end

    logic                   r_v2;
    logic [PW-1:0]          r_lhs;
    logic [PW-1:0]          r_rhs;
    logic [INPUT_WIDTH-1:0] r_pow2;

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_v2   <= 1'b0;
            r_lhs  <= '0;
            r_rhs  <= '0;
            r_pow2 <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_lhs  <= w_lhs;
                r_rhs  <= w_rhs;
                r_pow2 <= r_pow1;
            end
        end
    end

`ifdef ACORR_DETECTOR_METRIC_OUT_EN
    logic [MW-1:0] r_mag;

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n)
            r_mag <= '0;
        else if (r_v1)
            r_mag <= w_mag;
    end

    assign o_metric       = r_mag;
    assign o_metric_valid = r_v2;
`endif

    // Stage 3: qualification flag, tagged so idle cycles never reach the FSM.
    logic r_v3;
    logic r_qual;

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_v3   <= 1'b0;
            r_qual <= 1'b0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2)
                r_qual <= (r_lhs >= r_rhs) && (r_pow2 >= i_pow_floor) && (r_pow2 != '0);
        end
    end

    // Detection FSM
    state_t                   r_state;
    logic [7:0]               r_run_cnt;
    logic [HOLDOFF_WIDTH-1:0] r_hold_cnt;
    logic                     r_detect;
    logic [HOLDOFF_WIDTH-1:0] r_det_count;

    state_t                   w_state_nxt;
    logic [7:0]               w_run_nxt;
    logic [HOLDOFF_WIDTH-1:0] w_hold_nxt;
    logic                     w_fire;
    logic [7:0]               w_min_run_eff;
    logic [7:0]               w_run_inc;

    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_fire        = 1'b0;
        w_min_run_eff = (i_min_run == 8'd0) ? 8'd1 : i_min_run;
        w_run_inc     = r_run_cnt + 8'd1;
        if (r_v3) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_qual) begin
                        w_run_nxt = 8'd1;
                        if (w_min_run_eff == 8'd1)
                            w_fire = 1'b1;
                        else
                            w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_qual) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc >= w_min_run_eff)
                            w_fire = 1'b1;
                    end else begin
                        w_run_nxt   = 8'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // The sample that finds the counter already at zero is the last one ignored.
                    if (r_hold_cnt == '0)
                        w_state_nxt = ST_IDLE;
                    else
                        w_hold_nxt = r_hold_cnt - HOLD_ONE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            if (w_fire) begin
                w_run_nxt   = 8'd0;
                w_hold_nxt  = i_holdoff;
                w_state_nxt = (i_holdoff == '0) ? ST_IDLE : ST_HOLD;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_state     <= ST_IDLE;
            r_run_cnt   <= 8'd0;
            r_hold_cnt  <= '0;
            r_detect    <= 1'b0;
            r_det_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_cnt  <= w_run_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_detect   <= w_fire;
            if (w_fire && (r_det_count != '1))
                r_det_count <= r_det_count + HOLD_ONE;
        end
    end

    assign o_detect    = r_detect;
    assign o_det_count = r_det_count;
    assign o_state     = r_state;

endmodule

// File: tb/tb_acorr_detector.sv
// Self-checking bench for acorr_detector: directed scenarios plus randomized phases against a sample-level model.
module tb_acorr_detector;

  localparam int IW = 39;
  localparam int TW = 8;
  localparam int HW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [IW-1:0] i_acorr_re;
  logic [IW-1:0] i_acorr_im;
  logic [IW-1:0] i_power;
  logic          i_valid;
  logic [TW-1:0] i_thresh;
  logic [IW-1:0] i_pow_floor;
  logic [7:0]    i_min_run;
  logic [HW-1:0] i_holdoff;
  logic          o_detect;
  logic [HW-1:0] o_det_count;
  logic [1:0]    o_state;
`ifdef ACORR_DETECTOR_METRIC_OUT_EN
  logic [IW:0]   o_metric;
  logic          o_metric_valid;
`endif

  acorr_detector #(.INPUT_WIDTH(IW), .THRESH_WIDTH(TW), .HOLDOFF_WIDTH(HW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_acorr_re  (i_acorr_re),
    .i_acorr_im  (i_acorr_im),
    .i_power     (i_power),
    .i_valid     (i_valid),
    .i_thresh    (i_thresh),
    .i_pow_floor (i_pow_floor),
    .i_min_run   (i_min_run),
    .i_holdoff   (i_holdoff),
    .o_detect    (o_detect),
    .o_det_count (o_det_count),
`ifdef ACORR_DETECTOR_METRIC_OUT_EN
    .o_metric       (o_metric),
    .o_metric_valid (o_metric_valid),
`endif
    .o_state     (o_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // scoreboard: one entry per valid sample, due 4 bench cycles after it is driven
  typedef struct packed {
    longint      t;
    logic        det;
    logic [15:0] cnt;
    logic [1:0]  st;
  } exp_t;
  exp_t exp_q[$];

  int          m_run;
  int          m_skip;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic longint sabs(input logic [IW-1:0] x);
    longint v;
    longint lim;
    v   = longint'($signed(x));
    lim = longint'(1) << (IW - 1);
    if (v == -lim) return lim - 1;
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit model_qual(input logic [IW-1:0] re, input logic [IW-1:0] im,
                                    input logic [IW-1:0] pw);
    longint a, b, mag, p, fl;
    a   = sabs(re);
    b   = sabs(im);
    mag = (a > b) ? a + b / 2 : b + a / 2;
    p   = pw;
    fl  = i_pow_floor;
    return (mag * 32 >= p * longint'(i_thresh)) && (p >= fl) && (p != 0);
  endfunction

  task automatic model_sample(input bit q);
    exp_t e;
    int   need;
    e.t   = cyc + 4;
    e.det = 1'b0;
    need  = (i_min_run == 0) ? 1 : int'(i_min_run);
    if (m_skip > 0) begin
      m_skip--;
      e.st = (m_skip > 0) ? 2'd2 : 2'd0;
    end else if (q) begin
      m_run++;
      if (m_run >= need) begin
        e.det = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
        m_run  = 0;
        m_skip = (i_holdoff == 0) ? 0 : int'(i_holdoff) + 1;
        e.st   = (m_skip > 0) ? 2'd2 : 2'd0;
      end else begin
        e.st = 2'd1;
      end
    end else begin
      m_run = 0;
      e.st  = 2'd0;
    end
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge i_clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      e = exp_q.pop_front();
      check("detect", 64'(o_detect), 64'(e.det));
      check("det_count", 64'(o_det_count), 64'(e.cnt));
      check("state", 64'(o_state), 64'(e.st));
    end else begin
      check("no_detect", 64'(o_detect), 64'd0);
    end
  endtask

  // driver tasks
  task automatic drive(input bit v, input logic [IW-1:0] re, input logic [IW-1:0] im,
                       input logic [IW-1:0] pw);
    i_valid    = v;
    i_acorr_re = re;
    i_acorr_im = im;
    i_power    = pw;
    if (v) model_sample(model_qual(re, im, pw));
    step();
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_run  = 0;
    m_skip = 0;
    m_cnt  = '0;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    model_clear();
    repeat (3) step();
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_count", 64'(o_det_count), 64'd0);
    i_rst_n = 1'b0;
    step();
  endtask

  task automatic set_cfg(input int th, input longint fl, input int mr, input int ho);
    i_thresh    = TW'(th);
    i_pow_floor = IW'(fl);
    i_min_run   = 8'(mr);
    i_holdoff   = HW'(ho);
  endtask

  localparam logic [IW-1:0] TONE = IW'(longint'(1) << 28);
  localparam logic [IW-1:0] ZERO = '0;

  initial begin
    logic [IW-1:0] re, im, pw;
    longint        r;
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_acorr_re = '0;
    i_acorr_im = '0;
    i_power = '0;
    set_cfg(16, 1, 8, 100);
    model_clear();

    // reset only, long quiet stretch
    repeat (4) step();
    i_rst_n = 1'b0;
    idle(1500);
    check("quiet_state", 64'(o_state), 64'd0);
    check("quiet_count", 64'(o_det_count), 64'd0);

    // noiseless tone, valid every 7th cycle: detections at samples 8, 117, 226
    do_reset();
    set_cfg(16, 1, 8, 100);
    for (int i = 0; i < 230; i++) begin
      drive(1'b1, TONE, ZERO, TONE);
      idle(6);
    end
    idle(5);
    check("tone_count", 64'(o_det_count), 64'd3);

    // broken run: 7 good, 1 bad, 8 good
    do_reset();
    set_cfg(16, 1, 8, 100);
    for (int i = 0; i < 16; i++)
      drive(1'b1, (i == 7) ? ZERO : TONE, ZERO, TONE);
    idle(6);
    check("broken_count", 64'(o_det_count), 64'd1);

    // power floor
    do_reset();
    set_cfg(16, 1000, 1, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, IW'(100), ZERO, IW'(100));
    idle(6);
    check("floor_block", 64'(o_det_count), 64'd0);
    set_cfg(16, 50, 1, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, IW'(100), ZERO, IW'(100));
    idle(6);
    check("floor_pass", 64'(o_det_count), 64'd4);

    // saturation and counter saturation
    do_reset();
    set_cfg(32, 1, 1, 0);
    re = {1'b1, {(IW-1){1'b0}}};
    pw = {2'b00, {(IW-2){1'b1}}};
    pw = {1'b0, {(IW-1){1'b1}}};
    drive(1'b1, re, re, pw);
    idle(1);
`ifdef ACORR_DETECTOR_METRIC_OUT_EN
    check("metric", 64'(o_metric), 64'((longint'(3) << 37) - 2));
    check("metric_valid", 64'(o_metric_valid), 64'd1);
`endif
    for (int i = 0; i < 70000; i++) drive(1'b1, re, re, pw);
    idle(6);
    check("sat_count", 64'(o_det_count), 64'hFFFF);

    // reset in the middle of a run
    do_reset();
    set_cfg(16, 1, 8, 10);
    for (int i = 0; i < 7; i++) drive(1'b1, TONE, ZERO, TONE);
    idle(1);
    i_rst_n = 1'b1;
    model_clear();
    idle(2);
    check("abort_state", 64'(o_state), 64'd0);
    i_rst_n = 1'b0;
    idle(4);
    for (int i = 0; i < 8; i++) drive(1'b1, TONE, ZERO, TONE);
    idle(6);
    check("restart_count", 64'(o_det_count), 64'd1);

    // randomized phases, configuration changed only with the pipeline drained
    do_reset();
    for (int ph = 0; ph < 20; ph++) begin
      set_cfg($urandom_range(0, 63),
              ($urandom_range(0, 3) == 0) ? 0 : longint'($urandom_range(0, 1 << 16)),
              $urandom_range(0, 5), $urandom_range(0, 6));
      for (int i = 0; i < 300; i++) begin
        r  = longint'($urandom_range(0, 1 << 19)) - (longint'(1) << 18);
        re = IW'(r);
        r  = longint'($urandom_range(0, 1 << 19)) - (longint'(1) << 18);
        im = IW'(r);
        pw = ($urandom_range(0, 15) == 0) ? ZERO : IW'($urandom_range(0, 1 << 17));
        drive($urandom_range(0, 9) < 7, re, im, pw);
      end
      idle(6);
    end
    check("rand_count", 64'(o_det_count), 64'(m_cnt));
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acorr_detector.md
ACORR_DETECTOR -- requirements
Module: acorr_detector

Interface
REQ-001 Parameter INPUT_WIDTH, default 39: width of the autocorrelation and power inputs.
REQ-002 Parameter THRESH_WIDTH, default 8: width of the threshold input, unsigned, 5 fractional bits.
REQ-003 Parameter HOLDOFF_WIDTH, default 16: width of the holdoff length and detection counter.
REQ-004 i_clk  input  1  clock.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-high.
REQ-006 i_acorr_re  input  INPUT_WIDTH  autocorrelation real part, signed.
REQ-007 i_acorr_im  input  INPUT_WIDTH  autocorrelation imaginary part, signed.
REQ-008 i_power  input  INPUT_WIDTH  moving power, unsigned.
REQ-009 i_valid  input  1  sample strobe; inputs are qualified only when high.
REQ-010 i_thresh  input  THRESH_WIDTH  detection ratio, in units of 1/32.
REQ-011 i_pow_floor  input  INPUT_WIDTH  minimum power for a sample to qualify.
REQ-012 i_min_run  input  8  consecutive qualifying samples needed to detect; 0 is treated as 1.
REQ-013 i_holdoff  input  HOLDOFF_WIDTH  valid samples ignored after a detection.
REQ-014 o_detect  output  1  single-cycle detection pulse.
REQ-015 o_det_count  output  HOLDOFF_WIDTH  count of detections, saturating.
REQ-016 o_state  output  2  FSM state: IDLE=0, RUN=1, HOLD=2.

Function
REQ-017 Stage 1 (registered, on i_valid) SHALL form |re| and |im|; the most-negative input SHALL saturate to its maximum positive value.
REQ-018 Stage 2 (registered) SHALL form mag = max(|re|,|im|) + (min(|re|,|im|) >> 1) in INPUT_WIDTH+1 bits; in parallel it SHALL form lhs = mag*32 and rhs = power*i_thresh, each in 48 bits unsigned, and carry power forward.
REQ-019 A sample SHALL qualify iff lhs >= rhs AND power >= i_pow_floor AND power != 0.
REQ-020 Valid tags SHALL travel with the data; cycles without i_valid SHALL NOT advance the FSM or its counters.
REQ-021 IDLE: a qualifying sample SHALL set run_cnt=1; if i_min_run<=1 the block SHALL detect immediately, else it SHALL go to RUN.
REQ-022 RUN: a qualifying sample SHALL increment run_cnt; when run_cnt reaches i_min_run the block SHALL detect. A non-qualifying valid sample SHALL clear run_cnt and return to IDLE.
REQ-023 Detect: o_detect SHALL be high for exactly one cycle, o_det_count SHALL increment (saturating at all-ones), hold_cnt SHALL load i_holdoff, and the FSM SHALL enter HOLD; if i_holdoff=0 it SHALL enter IDLE instead.
REQ-024 HOLD: each valid sample SHALL decrement hold_cnt; qualification SHALL be ignored; the sample on which hold_cnt reaches 0 SHALL return the FSM to IDLE, and that sample SHALL NOT start a run.
REQ-025 Latency: o_detect SHALL assert exactly 3 i_clk cycles after the rising i_clk edge that samples the completing i_valid.
REQ-026 i_thresh, i_pow_floor, i_min_run and i_holdoff SHALL be sampled in the cycle they are used; mid-run changes SHALL take effect on the next valid sample.
REQ-027 i_thresh=0 SHALL make every sample with power>=max(1,i_pow_floor) qualify.

Reset
REQ-028 Reset SHALL clear all pipeline registers, valid tags, run_cnt and hold_cnt; o_detect=0, o_det_count=0, o_state=IDLE.
REQ-029 Reset asserted mid-RUN or mid-HOLD SHALL abort the operation with no o_detect pulse; in-flight samples SHALL be discarded.

Configuration
REQ-030 Macro ACORR_DETECTOR_METRIC_OUT_EN: when defined, the block SHALL add ports o_metric (INPUT_WIDTH+1 bits, the stage-2 mag) and o_metric_valid, aligned with the stage-2 valid tag (2-cycle latency), both reset to 0; when undefined, these ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset only, 1500 cycles with no i_valid -> o_detect never high, o_det_count=0, o_state=0.
REQ-032 Noiseless tone: re=power=2^28, im=0, thresh=16, floor=1, min_run=8, holdoff=100, valid every 7th cycle -> first o_detect 3 cycles after the 8th valid; one detection per 109 valid samples.
REQ-033 Run broken: 7 qualifying samples, 1 with re=0, then 8 qualifying (min_run=8) -> exactly one detection, 3 cycles after the 16th sample.
REQ-034 Power floor: re=power=100, floor=1000 -> no detection; floor=50 -> detection.
REQ-035 Saturation: re=-2^38, im=-2^38, power=2^38-1, thresh=32 -> mag=3*(2^38-1)>>1 (stage-2 value) and qualifies; 70000 detections with min_run=1, holdoff=0 -> o_det_count=16'hFFFF.
REQ-036 Reset asserted at run_cnt=5 of 8 -> no pulse, o_state=0; detection restarts from a fresh run.
